// File: rtl/pwm_ramp_gen_pkg.sv
// pwm_ramp_gen_pkg: shared state encoding, default sizes and duty clamp helper
package pwm_ramp_gen_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;
  localparam int W_DEF = 5;
  localparam int MAX_COUNT_DEF = 20;
  function automatic int unsigned clamp_duty(input int unsigned cmd, input int unsigned max_count);
    return cmd > max_count ? max_count : cmd;
  endfunction
endpackage

// File: rtl/pwm_ramp_gen_if.sv
// pwm_ramp_gen_if: reference count, duty command, control levels and PWM status bundle
interface pwm_ramp_gen_if import pwm_ramp_gen_pkg::*; #(
  parameter int W = W_DEF
);
  logic [W-1:0] ref_count;
  logic [W-1:0] duty_cmd;
  logic [W-1:0] duty_act;
  logic         ref_en;
  logic         start;
  logic         stop;
  logic         fault;
  logic         fault_clr;
  logic         pwm_out;
  logic         period_tick;
  logic [1:0]   state_o;
  modport master (
    output ref_count, ref_en, duty_cmd, start, stop, fault, fault_clr,
    input  pwm_out, duty_act, period_tick, state_o
  );
  modport slave (
    input  ref_count, ref_en, duty_cmd, start, stop, fault, fault_clr,
    output pwm_out, duty_act, period_tick, state_o
  );
endinterface

// File: rtl/pwm_ramp_gen_ramp_step.sv
// pwm_ramp_gen_ramp_step: moves i_duty up to STEP toward i_target without overshoot or wrap
module pwm_ramp_gen_ramp_step #(
  parameter int W = 5,
  parameter int STEP = 1
) (
  input  logic [W-1:0] i_duty,
  input  logic [W-1:0] i_target,
  output logic [W-1:0] o_duty
);
  logic         w_up;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_step;
  always_comb begin
    w_up   = i_target > i_duty;
    w_diff = w_up ? i_target - i_duty : i_duty - i_target;
    w_step = w_diff < W'(STEP) ? w_diff : W'(STEP);
    o_duty = w_up ? i_duty + w_step : i_duty - w_step;
  end
endmodule

// File: rtl/pwm_ramp_gen.sv
// pwm_ramp_gen: soft-start/stop PWM against a 0..MAX_COUNT reference count (clk, reset active-low sync, bus slave)
module pwm_ramp_gen import pwm_ramp_gen_pkg::*; #(
  parameter int W = W_DEF,
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int STEP = 1,
  parameter int RAMP_DIV = 2
) (
  input logic           clk,
  input logic           reset,
  pwm_ramp_gen_if.slave bus
);
  localparam int DW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  state_t        r_state, w_state_nx;
  logic [W-1:0]  r_duty, w_duty_nx, w_target, w_step;
  logic [DW-1:0] r_div, w_div_nx;
  logic          r_pwm, r_tick;
  logic          w_boundary, w_update;
  assign w_boundary = bus.ref_en && bus.ref_count == W'(MAX_COUNT);
  assign w_update   = w_boundary && r_div == DW'(RAMP_DIV - 1);
  assign w_target   = bus.stop ? '0 : W'(clamp_duty(32'(bus.duty_cmd), MAX_COUNT));
  pwm_ramp_gen_ramp_step #(.W(W), .STEP(STEP)) u_step (
    .i_duty  (r_duty),
    .i_target(w_target),
    .o_duty  (w_step)
  );
  always_comb begin
    w_state_nx = r_state;
    w_duty_nx  = r_duty;
    w_div_nx   = r_div;
    if (bus.fault) begin
      w_state_nx = S_FAULT;
      w_duty_nx  = '0;
      w_div_nx   = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = bus.start && !bus.stop ? S_RAMP : S_IDLE;
        S_RAMP: if (w_boundary) begin
          w_div_nx = w_update ? '0 : r_div + DW'(1);
          if (w_update) begin
            w_duty_nx = w_step;
            if (w_step == w_target) w_state_nx = bus.stop ? S_IDLE : S_RUN;
          end
        end
        S_RUN: if (bus.stop || (w_boundary && w_target != r_duty)) begin
          w_state_nx = S_RAMP;
          w_div_nx   = '0;
        end
        default: w_state_nx = bus.fault_clr ? S_IDLE : S_FAULT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_duty  <= '0;
      r_div   <= '0;
      r_pwm   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_duty  <= w_duty_nx;
      r_div   <= w_div_nx;
      r_pwm   <= !bus.fault && (r_state == S_RAMP || r_state == S_RUN) && bus.ref_count < r_duty;
      r_tick  <= w_boundary;
    end
  end
  assign bus.pwm_out     = r_pwm;
  assign bus.duty_act    = r_duty;
  assign bus.period_tick = r_tick;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_pwm_ramp_gen.sv
// tb_pwm_ramp_gen: directed and randomized stimulus checked every cycle against a behavioural model
module tb_pwm_ramp_gen;
  localparam int W = 5;
  localparam int MAXC = 20;
  localparam int STEP = 1;
  localparam int DIV = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  pwm_ramp_gen_if #(.W(W)) bus ();
  pwm_ramp_gen #(.W(W), .MAX_COUNT(MAXC), .STEP(STEP), .RAMP_DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int m_state = 0;
  int m_duty = 0;
  int m_nb = 0;
  int m_pwm = 0;
  int m_tick = 0;
  int hi, tk, d0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model();
    int tgt, diff, mv;
    bit bnd;
    if (!reset) begin
      m_state = 0; m_duty = 0; m_nb = 0; m_pwm = 0; m_tick = 0;
      return;
    end
    bnd = bus.ref_en && cnt == MAXC;
    tgt = bus.stop ? 0 : (int'(bus.duty_cmd) > MAXC ? MAXC : int'(bus.duty_cmd));
    m_pwm = (!bus.fault && (m_state == 1 || m_state == 2) && cnt < m_duty) ? 1 : 0;
    m_tick = bnd ? 1 : 0;
    if (bus.fault) begin
      m_state = 3; m_duty = 0; m_nb = 0;
    end else if (m_state == 3) begin
      if (bus.fault_clr) m_state = 0;
    end else if (m_state == 0) begin
      if (bus.start && !bus.stop) begin m_state = 1; m_nb = 0; end
    end else if (m_state == 2) begin
      if (bus.stop || (bnd && tgt != m_duty)) begin m_state = 1; m_nb = 0; end
    end else if (bnd) begin
      m_nb++;
      if (m_nb % DIV == 0) begin
        diff = tgt - m_duty;
        mv = diff > 0 ? (diff < STEP ? diff : STEP) : (-diff < STEP ? diff : -STEP);
        m_duty += mv;
        if (m_duty == tgt) m_state = bus.stop ? 0 : 2;
      end
    end
  endtask
  task automatic cyc();
    bus.ref_count = W'(cnt);
    model();
    @(posedge clk);
    #1;
    if (bus.ref_en) cnt = cnt == MAXC ? 0 : cnt + 1;
    bus.ref_count = W'(cnt);
    check("pwm", int'(bus.pwm_out), m_pwm);
    check("duty", int'(bus.duty_act), m_duty);
    check("tick", int'(bus.period_tick), m_tick);
    check("state", int'(bus.state_o), m_state);
  endtask
  task automatic run_until(input string tag, input int st, input int d, input int budget);
    int n = 0;
    while (!(int'(bus.state_o) == st && int'(bus.duty_act) == d) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_state"}, int'(bus.state_o), st);
    check({tag, "_duty"}, int'(bus.duty_act), d);
  endtask
  initial begin
    bus.ref_en = 1'b1; bus.duty_cmd = '0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.fault = 1'b0; bus.fault_clr = 1'b0; bus.ref_count = '0;
    repeat (4) cyc();
    reset = 1'b1;
    repeat (6) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_duty", int'(bus.duty_act), 0);
    check("rst_state", int'(bus.state_o), 0);
    reset = 1'b1;
    cyc();
    bus.duty_cmd = 5; bus.start = 1'b1;
    run_until("ramp5", 2, 5, 400);
    hi = 0; tk = 0;
    repeat (21) begin cyc(); hi += int'(bus.pwm_out); tk += int'(bus.period_tick); end
    check("hi5", hi, 5);
    check("tick1", tk, 1);
    bus.duty_cmd = 31;
    run_until("clamp", 2, 20, 2000);
    hi = 0;
    repeat (21) begin cyc(); hi += int'(bus.pwm_out); end
    check("hi20", hi, 20);
    bus.duty_cmd = 3;
    run_until("down3", 2, 3, 2000);
    bus.duty_cmd = 5;
    run_until("up5", 2, 5, 400);
    for (int n = 0; n < 30 && cnt != 7; n++) cyc();
    bus.fault = 1'b1;
    cyc();
    check("fault_pwm", int'(bus.pwm_out), 0);
    check("fault_state", int'(bus.state_o), 3);
    bus.fault_clr = 1'b1; cyc(); bus.fault_clr = 1'b0;
    repeat (3) cyc();
    check("clr_ignored", int'(bus.state_o), 3);
    bus.fault = 1'b0; cyc();
    check("fault_hold", int'(bus.state_o), 3);
    bus.fault_clr = 1'b1; bus.start = 1'b0; cyc(); bus.fault_clr = 1'b0;
    check("fault_exit", int'(bus.state_o), 0);
    bus.duty_cmd = 4; bus.start = 1'b1;
    run_until("run4", 2, 4, 1000);
    bus.stop = 1'b1;
    run_until("stop", 0, 0, 1000);
    bus.stop = 1'b0; bus.start = 1'b1; bus.duty_cmd = 10;
    repeat (50) cyc();
    bus.ref_en = 1'b0;
    d0 = int'(bus.duty_act); tk = 0;
    repeat (30) begin cyc(); tk += int'(bus.period_tick); end
    check("freeze_duty", int'(bus.duty_act), d0);
    check("freeze_tick", tk, 0);
    bus.ref_en = 1'b1;
    repeat (60) cyc();
    for (int i = 0; i < 4000; i++) begin
      bus.ref_en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 99) < 3) bus.duty_cmd = W'($urandom);
      if ($urandom_range(0, 99) < 2) bus.start = !bus.start;
      if ($urandom_range(0, 199) < 2) bus.stop = !bus.stop;
      if ($urandom_range(0, 399) < 2) bus.fault = !bus.fault;
      bus.fault_clr = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 499) != 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
